cce_deadlock_watchdog: RTL and testbench
========================================

# cce_deadlock_watchdog

Downstream consumer of the CCE_1_32 deadlock monitor's registered `block` output. It filters transient AXI-Stream stalls by counting consecutive blocked cycles. Once the count reaches a programmable threshold it declares a deadlock, latches a sticky flag, and emits one timestamped report record over a valid/ready handshake for the debug/status path. It holds that state until software clears it.

## Interface
Parameters:
- `THRESH`, default 1024: consecutive blocked cycles that constitute a deadlock. Legal range 1 .. 2^CNT_W-1.
- `CNT_W`, default 16: width of the run-length counter and of `report_len`.
- `TS_W`, default 32: width of the free-running timestamp and of `report_ts`.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `block_in` in 1: the monitor's `block` output, sampled every cycle.
- `clear` in 1: one-cycle software clear of a detected deadlock.
- `deadlock` out 1: sticky deadlock flag.
- `run_len` out CNT_W: current consecutive-blocked count, saturating.
- `report_valid` out 1: report record available.
- `report_ready` in 1: consumer accepts the record.
- `report_ts` out TS_W: timestamp of the first blocked cycle of the offending run.
- `report_len` out CNT_W: run length at detection (always THRESH).

## Operation
**Timestamp**
- `ts` is TS_W wide and is 0 in the first cycle after `reset` deasserts.
- It increments every cycle and wraps modulo 2^TS_W with no flag.

**Run counter**
- `run_len` increments on each cycle with `block_in`=1 and saturates at all-ones.
- It goes to 0 on any cycle with `block_in`=0 while in IDLE/COUNT.
- It goes to 0 on `clear`.

**FSM (states IDLE, COUNT, REPORT, HOLD)**
- **IDLE**
  - `block_in`=1: capture `start_ts`=`ts`, `run_len`<=1, then go to COUNT. If THRESH=1, go directly to REPORT instead.
  - Otherwise stay in IDLE.
- **COUNT**
  - `block_in`=1: `run_len`++. If the new value equals THRESH, go to REPORT.
  - `block_in`=0: `run_len`<=0, go to IDLE.
- **REPORT**
  - `report_valid`=1, `report_ts`=`start_ts`, `report_len`=THRESH.
  - Go to HOLD on the cycle `report_valid` & `report_ready`.
  - `block_in` is ignored for state decisions; `run_len` keeps counting while blocked and saturates.
- **HOLD**
  - `report_valid`=0 and `deadlock` stays 1.
  - `run_len` tracks `block_in` per the run-counter rules.
  - Only `clear` exits.

**Outputs**
- `deadlock` is 1 in REPORT and HOLD, and 0 in IDLE and COUNT.
- `report_ts` and `report_len` are stable whenever `report_valid`=1.
- `report_valid` never deasserts without a transfer, except on `clear` or `reset`.

**Clear**
- Honoured in every state. Next state is IDLE, with `run_len`=0, `deadlock`=0, `report_valid`=0.
- `clear` in REPORT abandons the pending record; no transfer occurs even if `report_ready`=1 in the same cycle.
- `clear` takes priority over `block_in`. A `block_in`=1 in the `clear` cycle is not counted; the next run starts at the following cycle.

**Reset**
- Registered outputs after reset: `deadlock`=0, `run_len`=0, `report_valid`=0, `report_ts`=0, `report_len`=0.
- FSM=IDLE, `ts`=0, `start_ts`=0.
- Reset mid-run or mid-report discards everything.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Run of N = THRESH blocked cycles:
  - `block_in`=1 sampled at edges e1..eN gives `deadlock`=1 and `report_valid`=1 in the cycle after eN.
  - `report_ts` = `ts` value present at e1.
- A single `block_in`=0 anywhere in e1..eN aborts the run. The next 1 restarts counting at 1 with a new `start_ts`.
- Handshake transfers on any edge where both `report_valid` and `report_ready` are high. `report_valid` drops the following cycle.
- `report_ready` held high before `report_valid` rises gives a one-cycle REPORT.
- Throughput: at most one report per `clear`.

## Test plan
Bench uses THRESH=4, CNT_W=8, TS_W=8.
- **Reset values:** reset for 3 cycles, then idle → all outputs 0 and `ts` increments from 0.
- **Short run:** `block_in`=1 for 3 cycles, then 0, `report_ready`=1 → `run_len` goes 1,2,3,0; `deadlock` and `report_valid` never assert.
- **Detection:** `block_in` rises at `ts`=10 and stays high, `report_ready`=1 → `report_valid` for one cycle, starting in the cycle after the fourth high sample, with `report_ts`=10 and `report_len`=4. `deadlock` stays 1.
- **Backpressure:** same as detection but `report_ready`=0 for 5 cycles, then 1 → `report_valid` and record held stable for 6 cycles; transfer on the 6th; `run_len` saturates at 255 under prolonged block.
- **Clear:**
  - `clear` pulsed in HOLD while `block_in`=1 → next cycle `deadlock`=0 and `run_len`=0; a new detection occurs exactly 4 blocked cycles later with a fresh `report_ts`.
  - `clear` pulsed together with `report_ready` in REPORT → no transfer, `deadlock`=0.
- **Wrap and reset mid-run:**
  - Start a 4-cycle block at `ts`=254 → `report_ts`=254, and `ts` wraps to 0 without effect.
  - Separately, assert `reset` after 2 blocked cycles → `run_len`=0 next cycle and no report.

Source files
------------

// File: rtl/cce_deadlock_watchdog.sv
// Deadlock watchdog: filters transient stalls on the monitor's block flag,
// latches a sticky deadlock and emits one timestamped report per clear.
module cce_deadlock_watchdog #(
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             block_in,
    input  logic             clear,
    output logic             deadlock,
    output logic [CNT_W-1:0] run_len,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [TS_W-1:0]  report_ts,
    output logic [CNT_W-1:0] report_len
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REPORT,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    state_t           state;
    state_t           state_nxt;
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  start_ts;
    logic [CNT_W-1:0] run_inc;
    logic             enter_report;

    assign run_inc = (run_len == '1) ? run_len : run_len + 1'b1;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (block_in) begin
                    state_nxt = (THRESH == 1) ? REPORT : COUNT;
                end
            end
            COUNT: begin
                if (!block_in) begin
                    state_nxt = IDLE;
                end else if (run_inc == THR) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (report_ready) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                state_nxt = HOLD;
            end
        endcase
        // Clear wins over both the handshake and a new blocked sample
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    assign enter_report = (state_nxt == REPORT) && (state != REPORT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ts         <= '0;
            start_ts   <= '0;
            run_len    <= '0;
            report_ts  <= '0;
            report_len <= '0;
        end else begin
            state <= state_nxt;
            ts    <= ts + 1'b1;
            if (clear || !block_in) begin
                run_len <= '0;
            end else if (state == IDLE) begin
                run_len <= CNT_W'(1);
            end else begin
                run_len <= run_inc;
            end
            if (!clear && block_in && state == IDLE) begin
                start_ts <= ts;
            end
            // A threshold of one reports straight from IDLE using this cycle's ts
            if (enter_report) begin
                report_ts  <= (state == IDLE) ? ts : start_ts;
                report_len <= THR;
            end
        end
    end

    assign deadlock     = (state == REPORT) || (state == HOLD);
    assign report_valid = (state == REPORT);

endmodule

// File: tb/tb_cce_deadlock_watchdog.sv
// Self-checking bench for cce_deadlock_watchdog (THRESH=4, CNT_W=8, TS_W=8).
// Report records are checked against a scoreboard queue at each transfer.
module tb_cce_deadlock_watchdog;

    logic       clock;
    logic       reset;
    logic       block_in;
    logic       clear;
    logic       deadlock;
    logic [7:0] run_len;
    logic       report_valid;
    logic       report_ready;
    logic [7:0] report_ts;
    logic [7:0] report_len;

    typedef struct {
        logic [7:0] ts;
        logic [7:0] len;
    } rec_t;

    rec_t       sb[$];
    logic [7:0] tb_ts;
    int         checks;
    int         errors;

    cce_deadlock_watchdog #(
        .THRESH(4),
        .CNT_W (8),
        .TS_W  (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .block_in    (block_in),
        .clear       (clear),
        .deadlock    (deadlock),
        .run_len     (run_len),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_ts   (report_ts),
        .report_len  (report_len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference timestamp: zero in the first cycle after reset, then +1 per cycle
    always @(posedge clock) begin
        if (reset) tb_ts <= 8'd0;
        else       tb_ts <= tb_ts + 8'd1;
    end

    always @(negedge clock) begin
        if (!reset && report_valid && report_ready && !clear) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected got ts=%0d len=%0d want none",
                         report_ts, report_len);
            end else begin
                rec_t e;
                e = sb.pop_front();
                if (report_ts !== e.ts || report_len !== e.len) begin
                    errors++;
                    $display("FAIL xfer_record got ts=%0d len=%0d want ts=%0d len=%0d",
                             report_ts, report_len, e.ts, e.len);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        block_in = 1'b0;
        clear = 1'b0;
        report_ready = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if ({deadlock, report_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got %b want 00", {deadlock, report_valid});
        end
        checks++;
        if (run_len !== 8'd0) begin
            errors++;
            $display("FAIL reset_run_len got %0d want 0", run_len);
        end
        checks++;
        if (report_ts !== 8'd0 || report_len !== 8'd0) begin
            errors++;
            $display("FAIL reset_record got %0d/%0d want 0/0", report_ts, report_len);
        end
    endtask

    task automatic test_short_run();
        report_ready = 1'b1;
        block_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) block_in = 1'b0;
            cyc();
            checks++;
            if (run_len !== ((i == 4) ? 8'd0 : 8'(i))) begin
                errors++;
                $display("FAIL short_run_len step %0d got %0d want %0d",
                         i, run_len, (i == 4) ? 0 : i);
            end
            checks++;
            if (deadlock !== 1'b0 || report_valid !== 1'b0) begin
                errors++;
                $display("FAIL short_run_flags got %b%b want 00", deadlock, report_valid);
            end
        end
    endtask

    // Drives four blocked samples from IDLE; expects the record after the fourth
    task automatic run_to_report(input string nm, input bit expect_xfer);
        logic [7:0] exp_ts;
        rec_t r;
        exp_ts = tb_ts;
        r.ts = exp_ts;
        r.len = 8'd4;
        if (expect_xfer) sb.push_back(r);
        block_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            checks++;
            if (report_valid !== (i == 4) || run_len !== 8'(i)) begin
                errors++;
                $display("FAIL %s_count step %0d got v=%b len=%0d want v=%b len=%0d",
                         nm, i, report_valid, run_len, i == 4, i);
            end
        end
        checks++;
        if (deadlock !== 1'b1 || report_ts !== exp_ts || report_len !== 8'd4) begin
            errors++;
            $display("FAIL %s_record got dl=%b ts=%0d len=%0d want dl=1 ts=%0d len=4",
                     nm, deadlock, report_ts, report_len, exp_ts);
        end
    endtask

    task automatic wait_ts(input logic [7:0] t, input string nm);
        for (int n = 0; n < 300 && tb_ts != t; n++) cyc();
        if (tb_ts != t) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_timeout got ts=%0d want %0d", nm, tb_ts, t);
        end
    endtask

    task automatic test_detection();
        block_in = 1'b0;
        report_ready = 1'b1;
        wait_ts(8'd10, "detect");
        run_to_report("detect", 1'b1);
        cyc();
        repeat (2) begin
            checks++;
            if (report_valid !== 1'b0 || deadlock !== 1'b1) begin
                errors++;
                $display("FAIL detect_hold got v=%b dl=%b want v=0 dl=1",
                         report_valid, deadlock);
            end
            cyc();
        end
    endtask

    task automatic test_clear_hold();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (deadlock !== 1'b0 || run_len !== 8'd0 || report_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_hold got dl=%b len=%0d v=%b want 0/0/0",
                     deadlock, run_len, report_valid);
        end
        run_to_report("reclear", 1'b1);
        cyc();
        block_in = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_ts;
        int vcnt;
        report_ready = 1'b0;
        exp_ts = tb_ts;
        run_to_report("bp", 1'b1);
        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (report_valid !== 1'b1 || report_ts !== exp_ts || report_len !== 8'd4) begin
                errors++;
                $display("FAIL bp_stable cyc %0d got v=%b ts=%0d len=%0d want 1/%0d/4",
                         k, report_valid, report_ts, report_len, exp_ts);
            end
            if (report_valid) vcnt++;
            cyc();
        end
        report_ready = 1'b1;
        if (report_valid) vcnt++;
        cyc();
        checks++;
        if (vcnt !== 6 || report_valid !== 1'b0 || deadlock !== 1'b1) begin
            errors++;
            $display("FAIL bp_xfer got vcycles=%0d v=%b dl=%b want 6/0/1",
                     vcnt, report_valid, deadlock);
        end
        repeat (260) cyc();
        checks++;
        if (run_len !== 8'd255) begin
            errors++;
            $display("FAIL bp_saturate got %0d want 255", run_len);
        end
        block_in = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_clear_report();
        report_ready = 1'b0;
        run_to_report("clr_rep", 1'b0);
        block_in = 1'b0;
        report_ready = 1'b1;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        report_ready = 1'b0;
        checks++;
        if (deadlock !== 1'b0 || report_valid !== 1'b0 || run_len !== 8'd0) begin
            errors++;
            $display("FAIL clear_report got dl=%b v=%b len=%0d want 0/0/0",
                     deadlock, report_valid, run_len);
        end
        cyc();
    endtask

    task automatic test_wrap_and_reset();
        report_ready = 1'b1;
        wait_ts(8'd254, "wrap");
        run_to_report("wrap", 1'b1);
        cyc();
        block_in = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        block_in = 1'b1;
        cyc();
        cyc();
        checks++;
        if (run_len !== 8'd2) begin
            errors++;
            $display("FAIL midrun_len got %0d want 2", run_len);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        block_in = 1'b0;
        checks++;
        if (run_len !== 8'd0 || report_ts !== 8'd0 || report_len !== 8'd0) begin
            errors++;
            $display("FAIL midrun_reset got len=%0d ts=%0d rl=%0d want 0/0/0",
                     run_len, report_ts, report_len);
        end
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++;
            if (report_valid !== 1'b0 || deadlock !== 1'b0) begin
                errors++;
                $display("FAIL midrun_noreport got v=%b dl=%b want 00",
                         report_valid, deadlock);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_short_run();
        test_detection();
        test_clear_hold();
        test_backpressure();
        test_clear_report();
        test_wrap_and_reset();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
